solution_sequence_gen: RTL and testbench

- Free-running 3-bit sequence generator.
- Steps a registered 3-bit output through a fixed cyclic pattern, selected at elaboration time, advancing on clock edges.
- No data inputs; used as a pattern/stimulus source and state sequencer.
- Only clock and reset are needed to drive it.

---
 rtl/solution_sequence_gen.sv | 92 +++++++++
 tb/tb_solution_sequence_gen.sv | 117 +++++++++++
 2 files changed

// File: rtl/solution_sequence_gen.sv
// Free-running 3-bit pattern generator (binary / Gray / Johnson / LFSR) with a clock prescaler.
// Define SEQ_GEN_REVERSE_EN to run every pattern backwards from the same start value.
module solution_sequence_gen #(
  parameter int MODE = 1,
  parameter int DIV  = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] out
);

  localparam int         M_EFF = (MODE >= 0 && MODE <= 3) ? MODE : 0;
  localparam int         D_EFF = (DIV < 1) ? 1 : ((DIV > 255) ? 255 : DIV);
  localparam logic [7:0] DIV_LAST = 8'(D_EFF - 1);
  localparam logic [2:0] START = (M_EFF == 3) ? 3'b001 : 3'b000;

  logic [7:0] r_div_cnt;
  logic [2:0] r_out;
  logic [2:0] w_next;
  logic       w_tick;

  assign w_tick = (r_div_cnt == DIV_LAST);
  assign out    = r_out;

`ifdef SEQ_GEN_REVERSE_EN
  always_comb begin
    w_next = START;
    case (M_EFF)
      1: case (r_out)
           3'b000: w_next = 3'b100;
           3'b100: w_next = 3'b101;
           3'b101: w_next = 3'b111;
           3'b111: w_next = 3'b110;
           3'b110: w_next = 3'b010;
           3'b010: w_next = 3'b011;
           3'b011: w_next = 3'b001;
           default: w_next = 3'b000;
         endcase
      2: case (r_out)
           3'b000: w_next = 3'b100;
           3'b100: w_next = 3'b110;
           3'b110: w_next = 3'b111;
           3'b111: w_next = 3'b011;
           3'b011: w_next = 3'b001;
           default: w_next = 3'b000;  // 001 wraps; 010/101 recover
         endcase
      // Inverse of the forward LFSR step; the lock-up state 000 still escapes to 001.
      3: w_next = (r_out == 3'b000) ? 3'b001 : {r_out[0] ^ r_out[2], r_out[2], r_out[1]};
      default: w_next = r_out - 3'd1;
    endcase
  end
`else
  always_comb begin
    w_next = START;
    case (M_EFF)
      1: case (r_out)
           3'b000: w_next = 3'b001;
           3'b001: w_next = 3'b011;
           3'b011: w_next = 3'b010;
           3'b010: w_next = 3'b110;
           3'b110: w_next = 3'b111;
           3'b111: w_next = 3'b101;
           3'b101: w_next = 3'b100;
           default: w_next = 3'b000;
         endcase
      2: case (r_out)
           3'b000: w_next = 3'b001;
           3'b001: w_next = 3'b011;
           3'b011: w_next = 3'b111;
           3'b111: w_next = 3'b110;
           3'b110: w_next = 3'b100;
           default: w_next = 3'b000;  // 100 wraps; 010/101 recover
         endcase
      3: w_next = (r_out == 3'b000) ? 3'b001 : {r_out[1:0], r_out[2] ^ r_out[1]};
      default: w_next = r_out + 3'd1;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= 8'd0;
      r_out     <= START;
    end else if (w_tick) begin
      r_div_cnt <= 8'd0;
      r_out     <= w_next;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_solution_sequence_gen.sv
// Directed bench: five generator variants share clk/rst; expected patterns are hand-written tables.
module tb_solution_sequence_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] out_g1, out_m0, out_m2, out_m3, out_d3;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  solution_sequence_gen #(.MODE(1), .DIV(1)) u_g1 (.clk(clk), .rst(rst), .out(out_g1));
  solution_sequence_gen #(.MODE(0), .DIV(1)) u_m0 (.clk(clk), .rst(rst), .out(out_m0));
  solution_sequence_gen #(.MODE(2), .DIV(1)) u_m2 (.clk(clk), .rst(rst), .out(out_m2));
  solution_sequence_gen #(.MODE(3), .DIV(1)) u_m3 (.clk(clk), .rst(rst), .out(out_m3));
  solution_sequence_gen #(.MODE(1), .DIV(3)) u_d3 (.clk(clk), .rst(rst), .out(out_d3));

  logic [2:0] exp_g1 [9];
  logic [2:0] exp_m0 [9];
  logic [2:0] exp_m2 [9];
  logic [2:0] exp_m3 [9];
  logic [2:0] exp_d3 [9];
  logic [2:0] exp_g1_first;
  logic [2:0] exp_d3_third;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  initial begin
`ifdef SEQ_GEN_REVERSE_EN
    exp_g1 = '{3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000, 3'b100};
    exp_m0 = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000, 3'b111};
    exp_m2 = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000, 3'b100, 3'b110, 3'b111};
    exp_m3 = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b101, 3'b010, 3'b001, 3'b100, 3'b110};
    exp_d3 = '{3'b000, 3'b000, 3'b100, 3'b100, 3'b100, 3'b101, 3'b101, 3'b101, 3'b111};
    exp_g1_first = 3'b100;
    exp_d3_third = 3'b100;
`else
    exp_g1 = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
    exp_m0 = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b001};
    exp_m2 = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000, 3'b001, 3'b011, 3'b111};
    exp_m3 = '{3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001, 3'b010, 3'b101};
    exp_d3 = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b011, 3'b011, 3'b011, 3'b010};
    exp_g1_first = 3'b001;
    exp_d3_third = 3'b001;
`endif

    // Reset state while rst is held
    #7;
    chk("rst_g1", out_g1, 3'b000);
    chk("rst_m0", out_m0, 3'b000);
    chk("rst_m2", out_m2, 3'b000);
    chk("rst_m3", out_m3, 3'b001);
    chk("rst_d3", out_d3, 3'b000);
    #3 rst = 1'b0;

    // Nine advances: full cycles plus wrap for each mode, prescaled instance alongside
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      chk($sformatf("seq_g1[%0d]", i), out_g1, exp_g1[i]);
      chk($sformatf("seq_m0[%0d]", i), out_m0, exp_m0[i]);
      chk($sformatf("seq_m2[%0d]", i), out_m2, exp_m2[i]);
      chk($sformatf("seq_m3[%0d]", i), out_m3, exp_m3[i]);
      chk($sformatf("seq_d3[%0d]", i), out_d3, exp_d3[i]);
    end

    // Illegal-state recovery: plant 010/101 in Johnson, 000 in LFSR
    force u_m2.r_out = 3'b010;
    force u_m3.r_out = 3'b000;
    #1;
    release u_m2.r_out;
    release u_m3.r_out;
    @(posedge clk); #1;
    chk("rec_m2_010", out_m2, 3'b000);
    chk("rec_m3_000", out_m3, 3'b001);
    force u_m2.r_out = 3'b101;
    #1;
    release u_m2.r_out;
    @(posedge clk); #1;
    chk("rec_m2_101", out_m2, 3'b000);

    // Re-sync everything, run default instance to 110, then pulse reset between edges
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_async_g1", out_g1, 3'b110);
    #2 rst = 1'b1;
    #1;
    chk("async_g1", out_g1, 3'b000);
    chk("async_m3", out_m3, 3'b001);
    chk("async_d3", out_d3, 3'b000);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("restart_g1", out_g1, exp_g1_first);
    chk("restart_d3_e1", out_d3, 3'b000);
    @(posedge clk); #1;
    chk("restart_d3_e2", out_d3, 3'b000);
    @(posedge clk); #1;
    chk("restart_d3_e3", out_d3, exp_d3_third);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
